// File: rtl/aib_adapt_syncfifo_ctrl.sv
// aib_adapt_syncfifo_ctrl
// Single-clock FIFO pointer/status controller. Drives the write/read selects
// of an external register-array FIFO (holds no data). DEPTH may be any value
// 2..2^AWIDTH. Provides occupancy, full/empty, programmable almost-full /
// almost-empty, sticky overflow/underflow and a synchronous flush.
//
// Optional build macro AIB_SYNCFIFO_NOCHK_EN: removes full/empty gating so
// both pointers always advance; occupancy is then tracked with lap bits and
// reported modulo 2*DEPTH, while overflow/underflow still flag requests that
// the checked controller would have dropped.
module aib_adapt_syncfifo_ctrl #(
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [AWIDTH:0]   af_thresh,
  input  logic [AWIDTH:0]   ae_thresh,
  output logic [DEPTH-1:0]  wr_ptr_one_hot,
  output logic [DEPTH-1:0]  rd_ptr_one_hot,
  output logic [AWIDTH-1:0] wr_ptr_bin,
  output logic [AWIDTH-1:0] rd_ptr_bin,
  output logic [AWIDTH:0]   numdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AWIDTH-1:0] LAST_PTR  = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   DEPTH_CNT = (AWIDTH + 1)'(DEPTH);

  logic [AWIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AWIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AWIDTH:0]   count_reg, count_next;
  logic              full_reg, full_next;
  logic              empty_reg, empty_next;
  logic              af_reg, af_next;
  logic              ae_reg, ae_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;
  logic              wr_acc, rd_acc;
  logic              wr_drop, rd_drop;
  logic              clear;

  // rst and flush clear identical state; rst wins only in the sense that
  // both produce the same all-zero result.
  assign clear = rst | flush;

  // Wrap at DEPTH-1 so non-power-of-two depths never reach unused slots.
  function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef AIB_SYNCFIFO_NOCHK_EN
  localparam int PW = AWIDTH + 2;

  logic          wr_lap_reg, wr_lap_next;
  logic          rd_lap_reg, rd_lap_next;
  logic [PW-1:0] wr_pos, rd_pos, pos_diff;

  // Unchecked acceptance; errors flag what the checked controller would drop.
  always_comb begin
    wr_acc  = wr_en;
    rd_acc  = rd_en;
    wr_drop = wr_en & full_reg & ~rd_en;
    rd_drop = rd_en & empty_reg;
  end

  // Pointer, lap and modulo-2*DEPTH occupancy next state.
  always_comb begin
    wr_ptr_next = wr_acc ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_lap_next = wr_lap_reg ^ (wr_acc & (wr_ptr_reg == LAST_PTR));
    rd_lap_next = rd_lap_reg ^ (rd_acc & (rd_ptr_reg == LAST_PTR));
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      wr_lap_next = 1'b0;
      rd_lap_next = 1'b0;
    end
    wr_pos   = (wr_lap_next ? PW'(DEPTH) : PW'(0)) + PW'(wr_ptr_next);
    rd_pos   = (rd_lap_next ? PW'(DEPTH) : PW'(0)) + PW'(rd_ptr_next);
    pos_diff = (wr_pos >= rd_pos) ? (wr_pos - rd_pos)
                                  : (wr_pos + PW'(2 * DEPTH) - rd_pos);
    count_next = (AWIDTH + 1)'(pos_diff);
  end

  // Lap bits live only in this build.
  always_ff @(posedge clk) begin
    wr_lap_reg <= wr_lap_next;
    rd_lap_reg <= rd_lap_next;
  end
`else
  // Checked acceptance: reads need data; writes need space or a same-cycle read.
  always_comb begin
    rd_acc  = rd_en & ~empty_reg;
    wr_acc  = wr_en & (~full_reg | rd_acc);
    wr_drop = wr_en & ~wr_acc;
    rd_drop = rd_en & ~rd_acc;
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_next = wr_acc ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + (AWIDTH + 1)'(1);
      2'b01:   count_next = count_reg - (AWIDTH + 1)'(1);
      default: count_next = count_reg;
    endcase
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end
`endif

  // Status flags derived from next-state count so they align with numdata.
  always_comb begin
    full_next  = (count_next == DEPTH_CNT);
    empty_next = (count_next == '0);
    af_next    = (count_next >= af_thresh);
    ae_next    = (count_next <= ae_thresh);
    ovf_next   = clear ? 1'b0 : (ovf_reg | wr_drop);
    udf_next   = clear ? 1'b0 : (udf_reg | rd_drop);
  end

  // State register; clear is already folded into every *_next value.
  always_ff @(posedge clk) begin
    wr_ptr_reg <= wr_ptr_next;
    rd_ptr_reg <= rd_ptr_next;
    count_reg  <= count_next;
    full_reg   <= full_next;
    empty_reg  <= empty_next;
    af_reg     <= af_next;
    ae_reg     <= ae_next;
    ovf_reg    <= ovf_next;
    udf_reg    <= udf_next;
  end

  // One-hot selects decoded from the registered binary pointers.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_onehot
    assign wr_ptr_one_hot[gi] = (wr_ptr_reg == AWIDTH'(gi));
    assign rd_ptr_one_hot[gi] = (rd_ptr_reg == AWIDTH'(gi));
  end

  assign wr_ptr_bin   = wr_ptr_reg;
  assign rd_ptr_bin   = rd_ptr_reg;
  assign numdata      = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;

endmodule

// File: tb/tb_aib_adapt_syncfifo_ctrl.sv
// Testbench for aib_adapt_syncfifo_ctrl: a DEPTH=16 instance driven from a
// vector table plus a DEPTH=12 instance exercised by a small reference model.
module tb_aib_adapt_syncfifo_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [AW:0] af_thresh = 5'd12;
  logic [AW:0] ae_thresh = 5'd3;

  logic [15:0]   a_wr_oh, a_rd_oh;
  logic [AW-1:0] a_wp, a_rp;
  logic [AW:0]   a_n;
  logic a_full, a_empty, a_af, a_ae, a_ovf, a_udf;

  logic [11:0]   b_wr_oh, b_rd_oh;
  logic [AW-1:0] b_wp, b_rp;
  logic [AW:0]   b_n;
  logic b_full, b_empty, b_af, b_ae, b_ovf, b_udf;

  always #5 clk = ~clk;

  aib_adapt_syncfifo_ctrl #(.AWIDTH(AW), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .wr_ptr_one_hot(a_wr_oh), .rd_ptr_one_hot(a_rd_oh),
    .wr_ptr_bin(a_wp), .rd_ptr_bin(a_rp), .numdata(a_n),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_udf)
  );

  aib_adapt_syncfifo_ctrl #(.AWIDTH(AW), .DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .wr_ptr_one_hot(b_wr_oh), .rd_ptr_one_hot(b_rd_oh),
    .wr_ptr_bin(b_wp), .rd_ptr_bin(b_rp), .numdata(b_n),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_udf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r, f, w, d;
    int   n, wp, rp;
    logic ovf, udf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, f, w, d, input int n, wp, rp,
                              input logic ovf, udf);
    vec_t v;
    v.r = r; v.f = f; v.w = w; v.d = d;
    v.n = n; v.wp = wp; v.rp = rp; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  // Apply one cycle of inputs and sample 1 time unit after the edge.
  task automatic step(input logic r, f, w, d);
    rst = r; flush = f; wr_en = w; rd_en = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- vector table for DEPTH=16 (af_thresh=12, ae_thresh=3) ----
    add(1,0,0,0, 0,0,0, 0,0);                                  // reset
    for (int i = 1; i <= 16; i++) add(0,0,1,0, i, i % 16, 0, 0,0); // fill
    add(0,0,1,0, 16,0,0, 1,0);                                 // write while full
    add(0,0,0,0, 16,0,0, 1,0);                                 // overflow sticky
    add(0,1,0,0, 0,0,0, 0,0);                                  // flush
    for (int i = 1; i <= 16; i++) add(0,0,1,0, i, i % 16, 0, 0,0);
    for (int i = 1; i <= 5; i++)  add(0,0,1,1, 16, i, i, 0,0);  // pass-through
    add(0,1,1,1, 0,0,0, 0,0);                                  // flush ignores ops
    add(0,0,1,1, 1,1,0, 0,1);                                  // empty wr+rd
    add(0,0,0,1, 0,1,1, 0,1);                                  // drain
    add(0,0,0,1, 0,1,1, 0,1);                                  // read on empty
    add(0,0,1,0, 1,2,1, 0,1);
    add(1,1,1,1, 0,0,0, 0,0);                                  // rst with flush
    for (int i = 1; i <= 5; i++)  add(0,0,1,0, i, i, 0, 0,0);
    add(1,0,1,0, 0,0,0, 0,0);                                  // rst mid-fill

    foreach (vecs[k]) begin
      logic [15:0] oh_w, oh_r;
      vec_t v;
      v = vecs[k];
      step(v.r, v.f, v.w, v.d);
      oh_w = 16'd1 << v.wp;
      oh_r = 16'd1 << v.rp;
      $display("vec %0d: rst=%b flush=%b wr=%b rd=%b -> numdata=%0d wp=%0d rp=%0d full=%b empty=%b af=%b ae=%b ovf=%b udf=%b",
               k, v.r, v.f, v.w, v.d, a_n, a_wp, a_rp, a_full, a_empty, a_af, a_ae, a_ovf, a_udf);
      chk("numdata",   32'(a_n),     32'(v.n));
      chk("wr_ptr",    32'(a_wp),    32'(v.wp));
      chk("rd_ptr",    32'(a_rp),    32'(v.rp));
      chk("wr_onehot", 32'(a_wr_oh), 32'(oh_w));
      chk("rd_onehot", 32'(a_rd_oh), 32'(oh_r));
      chk("full",      32'(a_full),  32'(v.n == 16));
      chk("empty",     32'(a_empty), 32'(v.n == 0));
      chk("almost_full",  32'(a_af), 32'(v.n >= 12));
      chk("almost_empty", 32'(a_ae), 32'(v.n <= 3));
      chk("overflow",  32'(a_ovf),   32'(v.ovf));
      chk("underflow", 32'(a_udf),   32'(v.udf));
    end

    // ---- af_thresh = 0: almost_full asserts straight out of reset ----
    af_thresh = 5'd0;
    step(1,0,0,0);
    $display("af_thresh=0 reset: almost_full=%b almost_empty=%b", a_af, a_ae);
    chk("af_thresh0_reset", 32'(a_af), 32'd1);
    // thresholds above DEPTH: almost_full never, almost_empty always
    af_thresh = 5'd20;
    ae_thresh = 5'd20;
    for (int i = 0; i < 17; i++) step(0,0,1,0);
    $display("thresh>DEPTH full: numdata=%0d almost_full=%b almost_empty=%b", a_n, a_af, a_ae);
    chk("af_high_thresh", 32'(a_af), 32'd0);
    chk("ae_high_thresh", 32'(a_ae), 32'd1);
    af_thresh = 5'd12;
    ae_thresh = 5'd3;

    // ---- DEPTH=12 instance against a reference model ----
    begin
      int  n, wp, rp;
      logic ovf, udf;
      n = 0; wp = 0; rp = 0; ovf = 0; udf = 0;
      step(1,0,0,0);
      for (int i = 0; i < 60; i++) begin
        logic w, d, racc, wacc;
        logic [11:0] oh_w, oh_r;
        if (i < 30) begin w = 1'b1; d = (i % 3) != 0; end
        else if (i < 44) begin w = 1'b1; d = 1'b0; end
        else begin w = 1'b0; d = 1'b1; end
        racc = d && (n > 0);
        wacc = w && ((n < 12) || racc);
        if (w && !wacc) ovf = 1'b1;
        if (d && !racc) udf = 1'b1;
        if (wacc) wp = (wp == 11) ? 0 : wp + 1;
        if (racc) rp = (rp == 11) ? 0 : rp + 1;
        n = n + int'(wacc) - int'(racc);
        step(0,0,w,d);
        oh_w = 12'd1 << wp;
        oh_r = 12'd1 << rp;
        $display("d12 cyc %0d: wr=%b rd=%b -> numdata=%0d wp=%0d rp=%0d full=%b empty=%b ovf=%b udf=%b",
                 i, w, d, b_n, b_wp, b_rp, b_full, b_empty, b_ovf, b_udf);
        chk("d12_numdata",   32'(b_n),     32'(n));
        chk("d12_wr_ptr",    32'(b_wp),    32'(wp));
        chk("d12_rd_ptr",    32'(b_rp),    32'(rp));
        chk("d12_wr_onehot", 32'(b_wr_oh), 32'(oh_w));
        chk("d12_rd_onehot", 32'(b_rd_oh), 32'(oh_r));
        chk("d12_full",      32'(b_full),  32'(n == 12));
        chk("d12_empty",     32'(b_empty), 32'(n == 0));
        chk("d12_overflow",  32'(b_ovf),   32'(ovf));
        chk("d12_underflow", 32'(b_udf),   32'(udf));
        chk("d12_wp_range",  32'(b_wp < 12), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
